// File: rtl/nic_fifo_mesh.sv
// Mesh NIC: processor-side register file over configurable-depth input/output flit FIFOs.
// Optional VC-polarity transmit gate enabled by defining NIC_POLARITY_GATE_EN.
module nic_fifo_mesh #(
    parameter int DATA_W    = 64,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    input  logic              nicEn,
    input  logic              nicEnWr,
    output logic [0:DATA_W-1] d_out,
    input  logic              net_si,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_ri,
    output logic              net_so,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_ro,
    input  logic              net_polarity
);

    localparam int IN_PW  = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
    localparam int OUT_PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [IN_PW-1:0]  IN_LAST  = IN_PW'(IN_DEPTH - 1);
    localparam logic [OUT_PW-1:0] OUT_LAST = OUT_PW'(OUT_DEPTH - 1);
    localparam logic [7:0]        IN_FULL  = 8'(IN_DEPTH);
    localparam logic [7:0]        OUT_FULL = 8'(OUT_DEPTH);

    localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    logic [0:DATA_W-1] in_mem  [IN_DEPTH];
    logic [0:DATA_W-1] out_mem [OUT_DEPTH];

    logic [IN_PW-1:0]  in_wr_ptr, in_rd_ptr;
    logic [OUT_PW-1:0] out_wr_ptr, out_rd_ptr;
    logic [7:0]        in_count, out_count;
    logic              in_ovf, out_ovf;

    logic              in_empty, in_full, out_empty, out_full;
    logic [0:DATA_W-1] in_head, out_head;
    logic              rd_en, wr_en;
    logic              in_push, in_pop, in_drop;
    logic              out_push, out_pop, out_drop;
    logic              vc_gate, send;
    logic [0:DATA_W-1] rd_data;

    function automatic logic [0:DATA_W-1] status_word(input logic [7:0] cnt, input logic empty,
                                                      input logic full, input logic ovf);
        return DATA_W'({ovf, full, empty, cnt});
    endfunction

    assign in_empty  = (in_count == 8'd0);
    assign in_full   = (in_count == IN_FULL);
    assign out_empty = (out_count == 8'd0);
    assign out_full  = (out_count == OUT_FULL);
    assign in_head   = in_mem[in_rd_ptr];
    assign out_head  = out_mem[out_rd_ptr];
    assign net_ri    = ~in_full;

    assign rd_en = nicEn & ~nicEnWr;
    assign wr_en = nicEn & nicEnWr;

`ifdef NIC_POLARITY_GATE_EN
    assign vc_gate = (out_head[0] == net_polarity);
`else
    // Polarity is deliberately ignored in this build.
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign vc_gate = 1'b1;
`endif

    assign send     = ~out_empty & net_ro & vc_gate;
    assign in_push  = net_si & ~in_full;
    assign in_drop  = net_si & in_full;
    assign in_pop   = rd_en & (addr == ADDR_IN_DATA) & ~in_empty;
    assign out_pop  = send;
    // A full output FIFO still takes the write when the network drains it at the same edge.
    assign out_push = wr_en & (addr == ADDR_OUT_DATA) & (~out_full | out_pop);
    assign out_drop = wr_en & (addr == ADDR_OUT_DATA) & out_full & ~out_pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_data = '0;
        unique case (addr)
            ADDR_IN_DATA:    rd_data = in_empty ? '0 : in_head;
            ADDR_IN_STATUS:  rd_data = status_word(in_count, in_empty, in_full, in_ovf);
            ADDR_OUT_DATA:   rd_data = out_empty ? '0 : out_head;
            ADDR_OUT_STATUS: rd_data = status_word(out_count, out_empty, out_full, out_ovf);
            default:         rd_data = '0;
        endcase
    end

    // NOTE: FIFO storage is not reset; the pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wr_ptr]   <= net_di;
        if (out_push) out_mem[out_wr_ptr] <= d_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            in_ovf     <= 1'b0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
            d_out      <= '0;
            net_so     <= 1'b0;
            net_do     <= '0;
        end else begin
            if (in_push) in_wr_ptr <= (in_wr_ptr == IN_LAST) ? '0 : in_wr_ptr + 1'b1;
            if (in_pop)  in_rd_ptr <= (in_rd_ptr == IN_LAST) ? '0 : in_rd_ptr + 1'b1;
            unique case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 8'd1;
                2'b01:   in_count <= in_count - 8'd1;
                default: in_count <= in_count;
            endcase

            if (out_push) out_wr_ptr <= (out_wr_ptr == OUT_LAST) ? '0 : out_wr_ptr + 1'b1;
            if (out_pop)  out_rd_ptr <= (out_rd_ptr == OUT_LAST) ? '0 : out_rd_ptr + 1'b1;
            unique case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 8'd1;
                2'b01:   out_count <= out_count - 8'd1;
                default: out_count <= out_count;
            endcase

            // A status read clears the sticky flag unless a drop happens at the same edge.
            if (in_drop)
                in_ovf <= 1'b1;
            else if (rd_en && addr == ADDR_IN_STATUS)
                in_ovf <= 1'b0;

            if (out_drop)
                out_ovf <= 1'b1;
            else if (rd_en && addr == ADDR_OUT_STATUS)
                out_ovf <= 1'b0;

            if (rd_en) d_out <= rd_data;

            net_so <= send;
            if (send) net_do <= out_head;
        end
    end

endmodule

// File: tb/tb_nic_fifo_mesh.sv
// Self-checking bench for nic_fifo_mesh: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_nic_fifo_mesh;

    localparam int DW = 64;
    localparam int OD = 4;
    localparam int ID = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    addr = '0;
    logic [DW-1:0] d_in = '0;
    logic          nicEn = 1'b0;
    logic          nicEnWr = 1'b0;
    logic [DW-1:0] d_out;
    logic          net_si = 1'b0;
    logic [DW-1:0] net_di = '0;
    logic          net_ri;
    logic          net_so;
    logic [DW-1:0] net_do;
    logic          net_ro = 1'b0;
    logic          net_polarity = 1'b0;

    nic_fifo_mesh #(.DATA_W(DW), .OUT_DEPTH(OD), .IN_DEPTH(ID)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .nicEn(nicEn),
        .nicEnWr(nicEnWr), .d_out(d_out), .net_si(net_si), .net_di(net_di),
        .net_ri(net_ri), .net_so(net_so), .net_do(net_do), .net_ro(net_ro),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: flit queues, sticky flags, expected registered outputs.
    logic [DW-1:0] m_in[$];
    logic [DW-1:0] m_out[$];
    logic          m_in_ovf, m_out_ovf;
    logic [DW-1:0] e_dout, e_do;
    logic          e_so;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] status(input int cnt, input int depth, input logic ovf);
        logic [DW-1:0] w;
        w = DW'(cnt);
        if (cnt == 0)     w = w + 64'h100;
        if (cnt == depth) w = w + 64'h200;
        if (ovf)          w = w + 64'h400;
        return w;
    endfunction

    function automatic logic gate_ok(input logic [DW-1:0] flit);
`ifdef NIC_POLARITY_GATE_EN
        return flit[DW-1] == net_polarity;
`else
        return 1'b1;
`endif
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic rd, wr, in_full, out_full, send, in_drop, out_drop;
        if (reset) begin
            m_in.delete();
            m_out.delete();
            m_in_ovf = 0; m_out_ovf = 0;
            e_dout = '0; e_so = 0; e_do = '0;
            return;
        end
        rd       = nicEn && !nicEnWr;
        wr       = nicEn && nicEnWr;
        in_full  = (m_in.size() == ID);
        out_full = (m_out.size() == OD);
        send     = 0;
        if (m_out.size() > 0) send = net_ro && gate_ok(m_out[0]);
        in_drop  = net_si && in_full;
        out_drop = wr && addr == 2'd2 && out_full && !send;

        if (rd) begin
            case (addr)
                2'd0: e_dout = (m_in.size() > 0) ? m_in[0] : '0;
                2'd1: e_dout = status(m_in.size(), ID, m_in_ovf);
                2'd2: e_dout = (m_out.size() > 0) ? m_out[0] : '0;
                default: e_dout = status(m_out.size(), OD, m_out_ovf);
            endcase
            if (addr == 2'd0 && m_in.size() > 0) void'(m_in.pop_front());
            if (addr == 2'd1) m_in_ovf = 0;
            if (addr == 2'd3) m_out_ovf = 0;
        end
        if (net_si && !in_full) m_in.push_back(net_di);
        if (in_drop) m_in_ovf = 1;

        e_so = send;
        if (send) e_do = m_out.pop_front();
        if (wr && addr == 2'd2 && !out_drop) m_out.push_back(d_in);
        if (out_drop) m_out_ovf = 1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("d_out", d_out, e_dout);
        check("net_so", DW'(net_so), DW'(e_so));
        check("net_do", net_do, e_do);
        check("net_ri", DW'(net_ri), DW'(m_in.size() != ID));
    endtask

    task automatic proc_wr(input logic [1:0] a, input logic [DW-1:0] d);
        nicEn = 1; nicEnWr = 1; addr = a; d_in = d;
        step();
        nicEn = 0; nicEnWr = 0;
    endtask

    task automatic proc_rd(input logic [1:0] a);
        nicEn = 1; nicEnWr = 0; addr = a;
        step();
        nicEn = 0;
    endtask

    initial begin
        reset = 1;
        step();
        reset = 0;
        step();

        // Single flit out to the network.
        proc_wr(2'd2, 64'd32);
        proc_rd(2'd3);
        check("tp1_status_one", d_out, 64'h1);
        net_ro = 1; net_polarity = 0;
        step();
        check("tp1_send_so", DW'(net_so), 64'd1);
        check("tp1_send_do", net_do, 64'd32);
        net_ro = 0;
        step();
        check("tp1_so_one_cycle", DW'(net_so), 64'd0);
        proc_rd(2'd3);
        check("tp1_status_empty", d_out, 64'h100);

        // Output overflow and sticky-flag clearing.
        for (int i = 0; i < OD; i++) proc_wr(2'd2, DW'(i + 1));
        proc_wr(2'd2, 64'd66);
        proc_rd(2'd3);
        check("tp2_full_ovf", d_out & 64'h600, 64'h600);
        proc_rd(2'd3);
        check("tp2_ovf_cleared", d_out & 64'h600, 64'h200);

        // Full FIFO, send and write at the same edge.
        net_ro = 1;
        proc_wr(2'd2, 64'd11);
        check("tp5_sent", DW'(net_so), 64'd1);
        net_ro = 0;
        proc_rd(2'd3);
        check("tp5_count4_no_ovf", d_out & 64'h4ff, 64'h4);
        net_ro = 1;
        for (int i = 0; i < OD; i++) step();
        check("tp5_last_flit", net_do, 64'd11);
        net_ro = 0;

        // Input FIFO fill then drain.
        net_si = 1; net_di = 64'd132;
        for (int i = 0; i < 20 && net_ri; i++) step();
        check("tp3_ri_low", DW'(net_ri), 64'd0);
        net_si = 0;
        for (int i = 0; i < ID; i++) begin
            proc_rd(2'd0);
            check("tp3_in_data", d_out, 64'd132);
        end
        proc_rd(2'd0);
        check("tp3_in_empty_data", d_out, 64'd0);
        proc_rd(2'd1);
        check("tp3_in_status", d_out, 64'h100);

`ifdef NIC_POLARITY_GATE_EN
        net_ro = 0; net_polarity = 0;
        proc_wr(2'd2, 64'h8000_0000_0000_0005);
        net_ro = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("tp4_gated", DW'(net_so), 64'd0);
        end
        net_polarity = 1;
        step();
        check("tp4_released", DW'(net_so), 64'd1);
        net_ro = 0; net_polarity = 0;
`endif

        // Reset with both FIFOs partially filled.
        net_ro = 0;
        proc_wr(2'd2, 64'd7);
        proc_wr(2'd2, 64'd8);
        net_si = 1; net_di = 64'd9;
        step();
        step();
        net_si = 0;
        reset = 1;
        step();
        reset = 0;
        check("tp6_so", DW'(net_so), 64'd0);
        check("tp6_ri", DW'(net_ri), 64'd1);
        proc_rd(2'd1);
        check("tp6_in_status", d_out, 64'h100);
        proc_rd(2'd3);
        check("tp6_out_status", d_out, 64'h100);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            nicEn        = ($urandom_range(0, 3) != 0);
            nicEnWr      = $urandom_range(0, 1);
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_si       = ($urandom_range(0, 2) != 0);
            net_di       = {$urandom, $urandom};
            net_ro       = ($urandom_range(0, 2) == 0);
            net_polarity = $urandom_range(0, 1);
            step();
        end
        reset = 0; nicEn = 0; net_si = 0; net_ro = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
